// File: rtl/pour_timer_resp_pkg.sv
// Shared definitions for the dispenser pour timers.
// Holds the responder state encoding and the default prescale divider
// that the other dispenser timers also use.
package pour_timer_resp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    ACK     = 2'b10,
    RELEASE = 2'b11
  } state_t;

  localparam int DEFAULT_PRESCALE_DIV = 4;

endpackage

// File: rtl/pour_timer_resp_tick_gen.sv
// Prescaler for the pour timer.
// Counts 0..DIV-1 while enabled and wraps; tick_o is high for the one
// cycle in which the count sits at its terminal value.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset
//   clr_i  - synchronous clear of the count (has priority over en_i)
//   en_i   - count enable
//   tick_o - terminal-count pulse
module tick_gen #(
  parameter int DIV = 4,
  parameter int W   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  logic [W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == W'(DIV - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       cnt_q <= '0;
    else if (clr_i)  cnt_q <= '0;
    else if (en_i)   cnt_q <= tick_o ? '0 : cnt_q + W'(1);
  end

endmodule

// File: rtl/pour_timer_resp.sv
// Responder side of the count2/count_ACK2 handshake of the dispenser.
// A request opens the valve for dur_ticks * PRESCALE_DIV cycles, then
// returns a one-cycle ack and waits for the request to drop.
// Ports:
//   clk        - clock, rising edge
//   RESET      - asynchronous active-high reset
//   count2     - pour request, held until the ack is seen
//   dur_ticks  - pour length in prescaler ticks, sampled on acceptance
//   abort      - early stop, only honoured while pouring
//   count_ACK2 - one-cycle acknowledge
//   valve_on   - valve drive
//   busy       - not idle
//   aborted    - last pour was ended by abort
//   pour_cnt   - completed, non-aborted pours (wraps)
module pour_timer_resp
  import pour_timer_resp_pkg::*;
#(
  parameter int PRESCALE_DIV = DEFAULT_PRESCALE_DIV,
  parameter int PRESCALE_W   = 8,
  parameter int DUR_W        = 8,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             count2,
  input  logic [DUR_W-1:0] dur_ticks,
  input  logic             abort,
  output logic             count_ACK2,
  output logic             valve_on,
  output logic             busy,
  output logic             aborted,
  output logic [CNT_W-1:0] pour_cnt
);

  state_t             state_q, state_d;
  logic [DUR_W-1:0]   dur_q, dur_d;
  logic               aborted_q, aborted_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               tick;

  assign accept = (state_q == IDLE) && count2;

  tick_gen #(
    .DIV (PRESCALE_DIV),
    .W   (PRESCALE_W)
  ) u_tick (
    .clk_i  (clk),
    .rst_i  (RESET),
    .clr_i  (accept),
    .en_i   (state_q == RUN),
    .tick_o (tick)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      dur_q     <= '0;
      aborted_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      dur_q     <= dur_d;
      aborted_q <= aborted_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next state and datapath updates
  always_comb begin
    state_d   = state_q;
    dur_d     = dur_q;
    aborted_d = aborted_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (count2) begin
          dur_d     = dur_ticks;
          aborted_d = 1'b0;
          // zero-length pour skips the valve entirely
          state_d   = (dur_ticks != '0) ? RUN : ACK;
        end
      end
      RUN: begin
        // abort takes precedence over a coincident natural finish
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ACK;
        end else if (tick) begin
          dur_d = dur_q - DUR_W'(1);
          if (dur_q == DUR_W'(1)) state_d = ACK;
        end
      end
      ACK: begin
        if (!aborted_q) cnt_d = cnt_q + CNT_W'(1);
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!count2) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    count_ACK2 = (state_q == ACK);
    valve_on   = (state_q == RUN);
    busy       = (state_q != IDLE);
    aborted    = aborted_q;
    pour_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_pour_timer_resp.sv
module tb_pour_timer_resp;

  logic       clk = 1'b0;
  logic       RESET;
  logic       count2;
  logic [7:0] dur_ticks;
  logic       abort;
  logic       count_ACK2;
  logic       valve_on;
  logic       busy;
  logic       aborted;
  logic [7:0] pour_cnt;

  int nvec = 0;
  int nmis = 0;
  int exp_cnt = 0;

  pour_timer_resp #(
    .PRESCALE_DIV (4),
    .PRESCALE_W   (8),
    .DUR_W        (8),
    .CNT_W        (8)
  ) dut (
    .clk        (clk),
    .RESET      (RESET),
    .count2     (count2),
    .dur_ticks  (dur_ticks),
    .abort      (abort),
    .count_ACK2 (count_ACK2),
    .valve_on   (valve_on),
    .busy       (busy),
    .aborted    (aborted),
    .pour_cnt   (pour_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One request from the requester side. Called #1 after a clock edge.
  // abort_at > 0 : pulse abort during that valve_on cycle
  // abort_at = -1: hold abort high for the whole transaction
  // hold         : cycles count2 stays high after the ack cycle
  task automatic pour(input logic [7:0] dur, input int abort_at, input int hold,
                      input int exp_v, input bit exp_ab, input string tag);
    int vcyc = 0, acyc = 0, first_v = -1, last_v = -1, ack_idx = -1;
    count2    = 1'b1;
    dur_ticks = dur;
    abort     = (abort_at == -1);
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk); #1;
      if (valve_on) begin
        vcyc++;
        if (first_v < 0) first_v = i;
        last_v = i;
      end
      if (count_ACK2) begin
        acyc++;
        if (ack_idx < 0) ack_idx = i;
      end
      // changes after acceptance must not matter
      dur_ticks = 8'($urandom);
      abort = (abort_at == -1) || (abort_at > 0 && valve_on && vcyc == abort_at);
      if (ack_idx > 0 && i >= ack_idx + hold) break;
    end
    if (exp_ab == 1'b0) exp_cnt = (exp_cnt + 1) % 256;
    chk({tag, ".valve_cycles"}, vcyc, exp_v);
    if (exp_v > 0) begin
      chk({tag, ".valve_first"}, first_v, 1);
      chk({tag, ".valve_last"},  last_v,  exp_v);
    end
    chk({tag, ".ack_idx"},    ack_idx, exp_v + 1);
    chk({tag, ".ack_count"},  acyc,    1);
    chk({tag, ".aborted"},    aborted, exp_ab);
    chk({tag, ".pour_cnt"},   pour_cnt, exp_cnt);
    if (hold > 0) chk({tag, ".busy_release"}, busy, 1);
    count2 = 1'b0;
    abort  = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".idle_after"}, busy, 0);
  endtask

  initial begin
    RESET = 1'b1; count2 = 1'b0; dur_ticks = 8'd0; abort = 1'b0;
    #2;
    chk("rst.busy",     busy,       0);
    chk("rst.valve",    valve_on,   0);
    chk("rst.ack",      count_ACK2, 0);
    chk("rst.aborted",  aborted,    0);
    chk("rst.pour_cnt", pour_cnt,   0);
    @(posedge clk); #1;
    RESET = 1'b0;
    @(posedge clk); #1;

    // 1: 3 ticks x 4 = 12 valve cycles, count2 held in RELEASE
    pour(8'd3, 0, 5, 12, 1'b0, "t1");
    // 2: zero-length pour; abort held high outside RUN is ignored
    pour(8'd0, -1, 2, 0, 1'b0, "t2");
    // 3: abort in the 6th valve cycle
    pour(8'd10, 6, 2, 6, 1'b1, "t3");
    // 4: back-to-back requester, drops count2 one cycle after ack
    for (int n = 0; n < 3; n++) pour(8'd2, 0, 1, 8, 1'b0, "t4");
    chk("t4.total", pour_cnt, 5);

    // 5: asynchronous reset mid-pour
    count2 = 1'b1; dur_ticks = 8'd5;
    repeat (3) @(posedge clk);
    #1;
    chk("t5.valve_pre", valve_on, 1);
    #2 RESET = 1'b1;
    #1;
    chk("t5.valve", valve_on,   0);
    chk("t5.busy",  busy,       0);
    chk("t5.cnt",   pour_cnt,   0);
    chk("t5.ack",   count_ACK2, 0);
    count2 = 1'b0;
    exp_cnt = 0;
    @(posedge clk); #1;
    RESET = 1'b0;
    @(posedge clk); #1;
    pour(8'd5, 0, 2, 20, 1'b0, "t5");

    // 6: counter wrap
    for (int n = 0; n < 254; n++) pour(8'd1, 0, 1, 4, 1'b0, "t6p");
    chk("t6.pre_wrap", pour_cnt, 255);
    pour(8'd1, 0, 1, 4, 1'b0, "t6w");
    chk("t6.wrapped", pour_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
